// File: rtl/image_pkg.sv
// Shared constants, state encoding and pixel mapping for the pixel unpacker.
// PIXEL_BINARIZE_EN selects thresholded (0x00 / all-ones) pixels instead of raw values.
package image_pkg;

    localparam int WORD_W  = 32;
    localparam int PIX_W   = 8;
    localparam int NUM_PIX = 784;
    localparam int ADDR_W  = 10;
    localparam int THRESH  = 128;
    localparam int LANES   = WORD_W / PIX_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        UNPACK,
        DONE
    } state_t;

    // Value actually written to the pixel RAM for one lane
    function automatic logic [PIX_W-1:0] pixelMap(input logic [PIX_W-1:0] lane);
`ifdef PIXEL_BINARIZE_EN
        return (lane >= PIX_W'(THRESH)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
        return lane;
`endif
    endfunction

endpackage

// File: rtl/word_pixel_unpacker_lane_shifter.sv
// Holds the lanes of the current word that are still waiting to be written,
// plus a count of which lane is on the write port right now. Lane 0 goes to
// the write register straight from the input word, so only lanes 1..LANES-1
// are kept here and oHead is always the next lane to write.
module lane_shifter
    import image_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iClear,
    input  logic              iLoad,
    input  logic              iShift,
    input  logic [WORD_W-1:0] iWord,
    output logic [PIX_W-1:0]  oHead,
    output logic              oLast
);

    logic [WORD_W-1:0] shiftReg;
    logic [LANE_W-1:0] laneCnt;

    // Clear beats load beats shift; load restarts the lane count at 0
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            shiftReg <= '0;
            laneCnt  <= '0;
        end else if (iClear) begin
            shiftReg <= '0;
            laneCnt  <= '0;
        end else if (iLoad) begin
            shiftReg <= iWord >> PIX_W;
            laneCnt  <= '0;
        end else if (iShift) begin
            shiftReg <= shiftReg >> PIX_W;
            laneCnt  <= laneCnt + LANE_W'(1);
        end
    end

    assign oHead = shiftReg[PIX_W-1:0];
    assign oLast = (laneCnt == LANE_W'(LANES - 1));

endmodule

// File: rtl/word_pixel_unpacker.sv
// Unpacks 32-bit words of four 8-bit pixels into sequential pixel RAM writes,
// one pixel per clock, for one 28x28 frame; flags frame completion and words
// offered after the frame is full.
// Optional: define PIXEL_BINARIZE_EN to write thresholded pixels.
module word_pixel_unpacker
    import image_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFrame_start,
    input  logic [WORD_W-1:0] iWord,
    input  logic              iWord_valid,
    output logic              oWord_ready,
    output logic              oPix_wr_en,
    output logic [ADDR_W-1:0] oPix_addr,
    output logic [PIX_W-1:0]  oPix_data,
    output logic              oBusy,
    output logic              oFrame_done,
    output logic              oOverrun
);

    state_t            state;
    logic [ADDR_W-1:0] addrReg;     // address the next written pixel will use
    logic              accept;
    logic              lastPix;     // pixel on the write port is the frame's last
    logic              lastLane;
    logic              shShift;
    logic              emit;
    logic [PIX_W-1:0]  emitSrc;
    logic [PIX_W-1:0]  head;

    lane_shifter uShifter (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iClear (iFrame_start),
        .iLoad  (accept),
        .iShift (shShift),
        .iWord  (iWord),
        .oHead  (head),
        .oLast  (lastLane)
    );

    assign lastPix = (oPix_addr == ADDR_W'(NUM_PIX - 1));

    // Ready in LOAD, or on the final lane of a word when the frame has room left; a frame start always blocks it
    always_comb begin
        oWord_ready = 1'b0;
        if (!iFrame_start) begin
            if (state == LOAD) begin
                oWord_ready = 1'b1;
            end else if (state == UNPACK && lastLane && !lastPix) begin
                oWord_ready = 1'b1;
            end
        end
    end

    assign accept  = iWord_valid && oWord_ready;
    assign shShift = (state == UNPACK) && !lastLane && !lastPix && !iFrame_start;

    // Choose the pixel for the next write: lane 0 of a freshly accepted word, else the next held lane
    always_comb begin
        emit    = 1'b0;
        emitSrc = iWord[PIX_W-1:0];
        if (accept) begin
            emit    = 1'b1;
            emitSrc = iWord[PIX_W-1:0];
        end else if (shShift) begin
            emit    = 1'b1;
            emitSrc = head;
        end
    end

    // Frame FSM, address counter, registered write port and sticky overrun flag
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= IDLE;
            addrReg    <= '0;
            oPix_wr_en <= 1'b0;
            oPix_addr  <= '0;
            oPix_data  <= '0;
            oOverrun   <= 1'b0;
        end else begin
            oPix_wr_en <= emit;
            if (emit) begin
                oPix_data <= pixelMap(emitSrc);
                oPix_addr <= addrReg;
                // Hold at the last pixel so the address never leaves the frame
                if (addrReg != ADDR_W'(NUM_PIX - 1)) begin
                    addrReg <= addrReg + ADDR_W'(1);
                end
            end
            if (iFrame_start) begin
                state    <= LOAD;
                addrReg  <= '0;
                oOverrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    LOAD: begin
                        if (accept) begin
                            state <= UNPACK;
                        end
                    end
                    UNPACK: begin
                        if (lastPix) begin
                            state <= DONE;
                        end else if (lastLane && !accept) begin
                            state <= LOAD;
                        end
                    end
                    DONE: begin
                        if (iWord_valid) begin
                            oOverrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign oBusy       = (state == LOAD) || (state == UNPACK);
    assign oFrame_done = (state == DONE);

endmodule

// File: tb/tb_word_pixel_unpacker.sv
// Scoreboard bench for word_pixel_unpacker: every accepted word pushes its
// expected pixel writes, every observed write pops and compares one.
`timescale 1ns/1ps
module tb_word_pixel_unpacker;
    import image_pkg::*;

    logic              iCLK = 1'b0;
    logic              iRST = 1'b0;
    logic              iFrame_start = 1'b0;
    logic [WORD_W-1:0] iWord = '0;
    logic              iWord_valid = 1'b0;
    logic              oWord_ready;
    logic              oPix_wr_en;
    logic [ADDR_W-1:0] oPix_addr;
    logic [PIX_W-1:0]  oPix_data;
    logic              oBusy;
    logic              oFrame_done;
    logic              oOverrun;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } pix_t;

    pix_t expQ[$];
    int   expAddr  = 0;
    int   passCnt  = 0;
    int   checkCnt = 0;
    int   wrCnt    = 0;
    int   stepCnt  = 0;

    word_pixel_unpacker dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iFrame_start (iFrame_start),
        .iWord        (iWord),
        .iWord_valid  (iWord_valid),
        .oWord_ready  (oWord_ready),
        .oPix_wr_en   (oPix_wr_en),
        .oPix_addr    (oPix_addr),
        .oPix_data    (oPix_data),
        .oBusy        (oBusy),
        .oFrame_done  (oFrame_done),
        .oOverrun     (oOverrun)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [PIX_W-1:0] refPixel(input logic [PIX_W-1:0] p);
`ifdef PIXEL_BINARIZE_EN
        refPixel = (int'(p) >= 128) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
        refPixel = p;
`endif
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input logic [WORD_W-1:0] w);
        pix_t e;
        for (int l = 0; l < LANES; l++) begin
            if (expAddr < NUM_PIX) begin
                e.addr = ADDR_W'(expAddr);
                e.data = refPixel(w[l*PIX_W +: PIX_W]);
                expQ.push_back(e);
                expAddr++;
            end
        end
    endtask

    // One clock: register the handshake seen before the edge, then check the write after it
    task automatic step();
        pix_t e;
        #2;
        if (iRST && iFrame_start) begin
            expQ.delete();
            expAddr = 0;
        end else if (iRST && iWord_valid && oWord_ready) begin
            $display("word 0x%08h accepted, first pixel address %0d", iWord, expAddr);
            pushWord(iWord);
        end
        @(posedge iCLK);
        #1;
        stepCnt++;
        if (oPix_wr_en) begin
            wrCnt++;
            checkEq("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkEq("wr_addr", 32'(oPix_addr), 32'(e.addr));
                checkEq("wr_data", 32'(oPix_data), 32'(e.data));
            end
            checkEq("wr_while_busy", 32'(oBusy), 32'd1);
        end
    endtask

    initial begin
        int  wr0;
        int  firstWr;
        int  lastWr;
        bit  hit;

        // Reset state
        repeat (2) step();
        checkEq("rst_wr_en", 32'(oPix_wr_en), 32'd0);
        checkEq("rst_addr", 32'(oPix_addr), 32'd0);
        checkEq("rst_data", 32'(oPix_data), 32'd0);
        checkEq("rst_ready", 32'(oWord_ready), 32'd0);
        checkEq("rst_busy", 32'(oBusy), 32'd0);
        checkEq("rst_done", 32'(oFrame_done), 32'd0);
        checkEq("rst_overrun", 32'(oOverrun), 32'd0);
        iRST = 1'b1;
        step();

        // Valid in IDLE is ignored
        iWord = 32'hDEADBEEF;
        iWord_valid = 1'b1;
        repeat (3) step();
        checkEq("idle_no_write", 32'(wrCnt), 32'd0);
        checkEq("idle_no_overrun", 32'(oOverrun), 32'd0);
        checkEq("idle_ready", 32'(oWord_ready), 32'd0);

        // Single word, latency N+1..N+4
        iWord_valid = 1'b0;
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        #1;
        checkEq("load_busy", 32'(oBusy), 32'd1);
        checkEq("load_ready", 32'(oWord_ready), 32'd1);
        iWord = 32'h44332211;
        iWord_valid = 1'b1;
        step();
        iWord_valid = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            checkEq("lane_wr_en", 32'(oPix_wr_en), 32'd1);
            checkEq("lane_busy", 32'(oBusy), 32'd1);
            checkEq("lane_done", 32'(oFrame_done), 32'd0);
            if (k < LANES - 1) step();
        end
        step();
        checkEq("word_end_wr_en", 32'(oPix_wr_en), 32'd0);
        checkEq("word_sb_drained", 32'(expQ.size()), 32'd0);

        // Random valid gaps, then abort mid-word at address 400
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            iWord_valid = ($urandom_range(0, 2) != 0);
            iWord = $urandom;
            step();
            if (oPix_wr_en && oPix_addr == ADDR_W'(400)) hit = 1'b1;
        end
        checkEq("abort_point_reached", 32'(hit), 32'd1);
        iFrame_start = 1'b1;
        iWord_valid = 1'b1;
        #1;
        checkEq("start_blocks_ready", 32'(oWord_ready), 32'd0);
        step();
        iFrame_start = 1'b0;
        iWord_valid = 1'b0;
        checkEq("abort_no_write", 32'(oPix_wr_en), 32'd0);
        wr0 = wrCnt;
        repeat (2) step();
        checkEq("abort_quiet", 32'(wrCnt - wr0), 32'd0);
        iWord = 32'hA55A3CC3;
        iWord_valid = 1'b1;
        step();
        iWord_valid = 1'b0;
        checkEq("restart_addr0", 32'(oPix_addr), 32'd0);
        repeat (4) step();
        checkEq("restart_sb_drained", 32'(expQ.size()), 32'd0);

        // Full frame with valid held high
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        iWord_valid = 1'b1;
        iWord = $urandom;
        wr0 = wrCnt;
        firstWr = -1;
        lastWr = -1;
        for (int i = 0; i < 1500 && !oFrame_done; i++) begin
            step();
            if (oPix_wr_en) begin
                if (firstWr < 0) firstWr = stepCnt;
                lastWr = stepCnt;
            end
            iWord = $urandom;
        end
        iWord_valid = 1'b0;
        checkEq("frame_done", 32'(oFrame_done), 32'd1);
        checkEq("frame_writes", 32'(wrCnt - wr0), 32'(NUM_PIX));
        checkEq("frame_gapless", 32'(lastWr - firstWr + 1), 32'(NUM_PIX));
        checkEq("done_after_last", 32'(stepCnt - lastWr), 32'd1);
        checkEq("done_ready", 32'(oWord_ready), 32'd0);
        checkEq("done_busy", 32'(oBusy), 32'd0);
        checkEq("frame_sb_drained", 32'(expQ.size()), 32'd0);
        step();
        checkEq("done_no_overrun", 32'(oOverrun), 32'd0);
        checkEq("done_held", 32'(oFrame_done), 32'd1);

        // Overrun: set by valid in DONE, sticky, cleared by frame start
        iWord_valid = 1'b1;
        step();
        iWord_valid = 1'b0;
        checkEq("overrun_set", 32'(oOverrun), 32'd1);
        repeat (3) step();
        checkEq("overrun_sticky", 32'(oOverrun), 32'd1);
        checkEq("overrun_no_write", 32'(oPix_wr_en), 32'd0);
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        checkEq("overrun_cleared", 32'(oOverrun), 32'd0);
        checkEq("restart_done_low", 32'(oFrame_done), 32'd0);

        // Threshold pattern word at addresses 0..3
        iWord = 32'h807F00FF;
        iWord_valid = 1'b1;
        step();
        iWord_valid = 1'b0;
        repeat (4) step();
        checkEq("bin_sb_drained", 32'(expQ.size()), 32'd0);

        // Asynchronous reset mid-word
        iWord = 32'h0F1E2D3C;
        iWord_valid = 1'b1;
        step();
        iWord_valid = 1'b0;
        step();
        iRST = 1'b0;
        #1;
        checkEq("midrst_wr_en", 32'(oPix_wr_en), 32'd0);
        checkEq("midrst_addr", 32'(oPix_addr), 32'd0);
        checkEq("midrst_data", 32'(oPix_data), 32'd0);
        checkEq("midrst_busy", 32'(oBusy), 32'd0);
        expQ.delete();
        expAddr = 0;
        step();
        iRST = 1'b1;
        step();
        checkEq("post_rst_ready", 32'(oWord_ready), 32'd0);
        checkEq("post_rst_busy", 32'(oBusy), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
